// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI command buffer: FSM states and entry layout.
package spi_pkg;

    localparam int WORD_W  = 11;
    localparam int RDATA_W = 9;
    localparam int ENTRY_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RDXFER
    } spi_state_t;

    // An entry is {cmd_bit, word}; the top bit selects command versus data write.
    function automatic logic entry_is_cmd(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1];
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous FIFO holding queued SPI entries; a push to a full FIFO is taken
// only when a pop happens in the same cycle.
module spi_cmd_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two); level tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/spi_cmd_buf.sv
// Buffers upstream command/data writes and reads toward an SPI engine.
// Define SPI_CMD_BUF_DROP_EN to drop (and flag in ovf) writes to a full FIFO instead of stalling them.
module spi_cmd_buf
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        up_din,
    input  logic                     up_cmd,
    input  logic                     up_wr,
    input  logic                     up_rd,
    output logic [RDATA_W-1:0]       up_dout,
    output logic                     up_ack,
    output logic [WORD_W-1:0]        sp_dout,
    output logic                     sp_cmd,
    output logic                     sp_wr,
    output logic                     sp_rd,
    input  logic [RDATA_W-1:0]       sp_din,
    input  logic                     sp_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    spi_state_t         state;
    logic               rd_pending;
    logic [WORD_W-1:0]  rd_word;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               wr_req;
    logic [ENTRY_W-1:0] new_entry;
    logic               wr_ack_set;

    assign wr_req    = up_cmd || up_wr;
    assign new_entry = {up_cmd, up_din};
    assign pop       = (state == XFER) && sp_ack;

`ifdef SPI_CMD_BUF_DROP_EN
    logic drop;

    assign drop       = wr_req && full && !pop;
    assign push       = wr_req && (!full || pop);
    assign push_entry = new_entry;
    assign wr_ack_set = push || drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`else
    logic               stall_valid;
    logic [ENTRY_W-1:0] stall_entry;

    // A stalled word goes in on the first cycle a slot is (or is being) freed.
    always_comb begin
        push       = 1'b0;
        push_entry = new_entry;
        if (stall_valid) begin
            push       = !full || pop;
            push_entry = stall_entry;
        end else if (wr_req) begin
            push = !full || pop;
        end
    end

    assign wr_ack_set = push;
    assign ovf        = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_valid <= 1'b0;
            stall_entry <= '0;
        end else if (stall_valid) begin
            if (push) begin
                stall_valid <= 1'b0;
            end
        end else if (wr_req && full && !pop) begin
            stall_valid <= 1'b1;
            stall_entry <= new_entry;
        end
    end
`endif

    spi_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Queued writes drain before a pending read so writes stay ahead of reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            rd_word    <= '0;
            up_dout    <= '0;
            up_ack     <= 1'b0;
            sp_dout    <= '0;
            sp_cmd     <= 1'b0;
            sp_wr      <= 1'b0;
            sp_rd      <= 1'b0;
        end else begin
            up_ack <= wr_ack_set;
            if (up_rd) begin
                rd_pending <= 1'b1;
                rd_word    <= up_din;
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= XFER;
                        sp_dout <= head[WORD_W-1:0];
                        sp_cmd  <= entry_is_cmd(head);
                        sp_wr   <= !entry_is_cmd(head);
                    end else if (rd_pending) begin
                        state   <= RDXFER;
                        sp_dout <= rd_word;
                        sp_rd   <= 1'b1;
                    end
                end
                XFER: begin
                    if (sp_ack) begin
                        state  <= IDLE;
                        sp_cmd <= 1'b0;
                        sp_wr  <= 1'b0;
                    end
                end
                RDXFER: begin
                    if (sp_ack) begin
                        state      <= IDLE;
                        sp_rd      <= 1'b0;
                        up_dout    <= sp_din;
                        up_ack     <= 1'b1;
                        rd_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_buf.sv
// Directed self-checking bench for spi_cmd_buf (DEPTH = 8).
module tb_spi_cmd_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] up_din;
    logic        up_cmd, up_wr, up_rd;
    logic [8:0]  up_dout;
    logic        up_ack;
    logic [10:0] sp_dout;
    logic        sp_cmd, sp_wr, sp_rd;
    logic [8:0]  sp_din;
    logic        sp_ack;
    logic [3:0]  level;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    spi_cmd_buf #(.DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .up_din  (up_din),
        .up_cmd  (up_cmd),
        .up_wr   (up_wr),
        .up_rd   (up_rd),
        .up_dout (up_dout),
        .up_ack  (up_ack),
        .sp_dout (sp_dout),
        .sp_cmd  (sp_cmd),
        .sp_wr   (sp_wr),
        .sp_rd   (sp_rd),
        .sp_din  (sp_din),
        .sp_ack  (sp_ack),
        .level   (level),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_write(input logic cmd, input logic [10:0] d);
        up_din = d;
        up_cmd = cmd;
        up_wr  = !cmd;
        tick();
        up_cmd = 1'b0;
        up_wr  = 1'b0;
    endtask

    task automatic give_ack();
        sp_ack = 1'b1;
        tick();
        sp_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        up_din = '0; up_cmd = 1'b0; up_wr = 1'b0; up_rd = 1'b0;
        sp_din = '0; sp_ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({up_dout, up_ack, sp_dout, sp_cmd, sp_wr, sp_rd, level, ovf} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {up_dout, up_ack, sp_dout, sp_cmd, sp_wr, sp_rd, level, ovf});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        pulse_write(1'b0, 11'h0A5);
        checks++;
        if (up_ack !== 1'b1 || level !== 4'd1) begin
            failures++;
            $display("[TB] FAIL single_ack: got ack=%b level=%0d expected ack=1 level=1", up_ack, level);
        end
        tick();
        checks++;
        if (up_ack !== 1'b0 || sp_wr !== 1'b1 || sp_cmd !== 1'b0 || sp_dout !== 11'h0A5) begin
            failures++;
            $display("[TB] FAIL single_req: got ack=%b wr=%b cmd=%b dout=%h expected 0 1 0 0a5",
                     up_ack, sp_wr, sp_cmd, sp_dout);
        end
        tick(); tick(); tick();
        checks++;
        if (sp_wr !== 1'b1 || sp_dout !== 11'h0A5) begin
            failures++;
            $display("[TB] FAIL single_hold: got wr=%b dout=%h expected 1 0a5", sp_wr, sp_dout);
        end
        give_ack();
        checks++;
        if (sp_wr !== 1'b0 || level !== 4'd0 || up_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_done: got wr=%b level=%0d ack=%b expected 0 0 0", sp_wr, level, up_ack);
        end
    endtask

    task automatic test_ordering();
        pulse_write(1'b1, 11'h403);
        tick();
        pulse_write(1'b0, 11'h055);
        checks++;
        if (up_ack !== 1'b1 || level !== 4'd2) begin
            failures++;
            $display("[TB] FAIL order_push: got ack=%b level=%0d expected 1 2", up_ack, level);
        end
        up_din = 11'h000;
        up_rd  = 1'b1;
        tick();
        up_rd  = 1'b0;
        checks++;
        if (sp_cmd !== 1'b1 || sp_wr !== 1'b0 || sp_rd !== 1'b0 || sp_dout !== 11'h403) begin
            failures++;
            $display("[TB] FAIL order_cmd: got cmd=%b wr=%b rd=%b dout=%h expected 1 0 0 403",
                     sp_cmd, sp_wr, sp_rd, sp_dout);
        end
        give_ack();
        tick();
        checks++;
        if (sp_wr !== 1'b1 || sp_cmd !== 1'b0 || sp_rd !== 1'b0 || sp_dout !== 11'h055) begin
            failures++;
            $display("[TB] FAIL order_wr: got cmd=%b wr=%b rd=%b dout=%h expected 0 1 0 055",
                     sp_cmd, sp_wr, sp_rd, sp_dout);
        end
        give_ack();
        tick();
        checks++;
        if (sp_rd !== 1'b1 || sp_wr !== 1'b0 || sp_cmd !== 1'b0 || sp_dout !== 11'h000 || up_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL order_rd: got cmd=%b wr=%b rd=%b dout=%h ack=%b expected 0 0 1 000 0",
                     sp_cmd, sp_wr, sp_rd, sp_dout, up_ack);
        end
        sp_din = 9'h1C3;
        give_ack();
        sp_din = 9'h000;
        checks++;
        if (up_ack !== 1'b1 || up_dout !== 9'h1C3 || sp_rd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL order_rdata: got ack=%b dout=%h rd=%b expected 1 1c3 0", up_ack, up_dout, sp_rd);
        end
        tick(); tick();
        checks++;
        if (up_ack !== 1'b0 || up_dout !== 9'h1C3 || sp_rd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL order_hold: got ack=%b dout=%h rd=%b expected 0 1c3 0", up_ack, up_dout, sp_rd);
        end
    endtask

    task automatic test_fill_wrap();
        logic [10:0] vals [9];
        int last;
        for (int i = 0; i < 9; i++) vals[i] = 11'h100 + 11'(i * 17);
        for (int i = 0; i < 8; i++) pulse_write(1'b0, vals[i]);
        checks++;
        if (level !== 4'd8 || sp_wr !== 1'b1 || sp_dout !== vals[0]) begin
            failures++;
            $display("[TB] FAIL fill_level: got level=%0d wr=%b dout=%h expected 8 1 %h", level, sp_wr, sp_dout, vals[0]);
        end
        pulse_write(1'b0, vals[8]);
`ifdef SPI_CMD_BUF_DROP_EN
        checks++;
        if (up_ack !== 1'b1 || ovf !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("[TB] FAIL fill_drop: got ack=%b ovf=%b level=%0d expected 1 1 8", up_ack, ovf, level);
        end
        last = 7;
        give_ack();
`else
        checks++;
        if (up_ack !== 1'b0 || level !== 4'd8) begin
            failures++;
            $display("[TB] FAIL fill_stall: got ack=%b level=%0d expected 0 8", up_ack, level);
        end
        tick(); tick(); tick();
        checks++;
        if (up_ack !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_stall_hold: got ack=%b ovf=%b expected 0 0", up_ack, ovf);
        end
        last = 8;
        give_ack();
        checks++;
        if (up_ack !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("[TB] FAIL fill_release: got ack=%b level=%0d expected 1 8", up_ack, level);
        end
`endif
        for (int i = 1; i <= last; i++) begin
            tick();
            checks++;
            if (sp_wr !== 1'b1 || sp_dout !== vals[i]) begin
                failures++;
                $display("[TB] FAIL drain_%0d: got wr=%b dout=%h expected 1 %h", i, sp_wr, sp_dout, vals[i]);
            end
            give_ack();
        end
        checks++;
        if (level !== 4'd0 || sp_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty: got level=%0d wr=%b expected 0 0", level, sp_wr);
        end
    endtask

    task automatic test_simultaneous();
        logic [10:0] vals [9];
        for (int i = 0; i < 9; i++) vals[i] = 11'h600 + 11'(i * 3);
        for (int i = 0; i < 8; i++) pulse_write(1'b0, vals[i]);
        up_din = vals[8];
        up_wr  = 1'b1;
        sp_ack = 1'b1;
        tick();
        up_wr  = 1'b0;
        sp_ack = 1'b0;
        checks++;
        if (up_ack !== 1'b1 || level !== 4'd8 || sp_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_push_pop: got ack=%b level=%0d wr=%b expected 1 8 0", up_ack, level, sp_wr);
        end
        for (int i = 1; i < 9; i++) begin
            tick();
            checks++;
            if (sp_wr !== 1'b1 || sp_dout !== vals[i]) begin
                failures++;
                $display("[TB] FAIL simul_drain_%0d: got wr=%b dout=%h expected 1 %h", i, sp_wr, sp_dout, vals[i]);
            end
            give_ack();
        end
        checks++;
        if (level !== 4'd0) begin
            failures++;
            $display("[TB] FAIL simul_empty: got level=%0d expected 0", level);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int acks;
        pulse_write(1'b0, 11'h2AA);
        tick();
        pulse_write(1'b0, 11'h155);
        checks++;
        if (sp_wr !== 1'b1 || up_ack !== 1'b1 || level !== 4'd2) begin
            failures++;
            $display("[TB] FAIL rstmid_pre: got wr=%b ack=%b level=%0d expected 1 1 2", sp_wr, up_ack, level);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({up_dout, up_ack, sp_dout, sp_cmd, sp_wr, sp_rd, level, ovf} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_async: got %h expected 0",
                     {up_dout, up_ack, sp_dout, sp_cmd, sp_wr, sp_rd, level, ovf});
        end
        tick();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (up_ack === 1'b1 || sp_wr === 1'b1 || sp_cmd === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0 || level !== 4'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_after: got activity=%0d level=%0d expected 0 0", acks, level);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  seen;
        logic [10:0] dv [3];
        int k;
        dv[0] = 11'h011; dv[1] = 11'h022; dv[2] = 11'h033;
        for (int i = 0; i < 3; i++) pulse_write(1'b0, dv[i]);
        seen = '0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            seen[c] = sp_wr;
            if (sp_wr === 1'b1) begin
                checks++;
                if (k > 2 || sp_dout !== dv[k]) begin
                    failures++;
                    $display("[TB] FAIL b2b_data_%0d: got %h expected %h", k, sp_dout, dv[k % 3]);
                end
                k++;
            end
            sp_ack = sp_wr;
            tick();
        end
        sp_ack = 1'b0;
        checks++;
        if (seen !== 6'b010101 || level !== 4'd0) begin
            failures++;
            $display("[TB] FAIL b2b_pattern: got %b level=%0d expected 010101 0", seen, level);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_ordering();
        test_fill_wrap();
        test_simultaneous();
        test_reset_mid_xfer();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
